// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with an output FIFO.
//   Synchronises and filters the raw PS/2 lines, detects falling edges of
//   the filtered clock, deframes start / DATA_WIDTH data (LSB first) /
//   odd parity / stop, and pushes good payloads into a first-word
//   fall-through FIFO.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   ps2_clk, ps2_data raw asynchronous PS/2 lines
//   data_out, valid   FIFO head and non-empty flag
//   ready             consumer pops the head when valid & ready
//   count             FIFO occupancy
//   err_parity/frame/timeout/overflow  single-cycle error pulses
//
// state  | meaning
// IDLE   | waiting for a start bit (sampled 0)
// DATA   | shifting payload bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking the stop bit, then push or flag an error
module ps2_rx_fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          valid,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic                          err_timeout,
    output logic                          err_overflow
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ---------------- input conditioning ----------------
    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic           fall_q;

    // Count consecutive samples that disagree with the filtered level;
    // any agreeing sample restarts the count, so short glitches vanish.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FCW'(FILTER_LEN - 1))
                filt_d = clk_s2_q;
            else
                filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= filt_q & ~filt_d;
        end
    end

    // ---------------- deframing FSM + watchdog ----------------
    state_t                state_q;
    logic [IW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_q;
    logic [TW-1:0]         wd_q;
    logic                  push_q;
    logic                  err_parity_q, err_frame_q, err_timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            wd_q          <= '0;
            push_q        <= 1'b0;
            err_parity_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            push_q        <= 1'b0;
            err_parity_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            if (fall_q) begin
                wd_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (!dat_s2_q) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end
                    end
                    DATA: begin
                        shift_q[idx_q] <= dat_s2_q;
                        if (idx_q == IW'(DATA_WIDTH - 1))
                            state_q <= PARITY;
                        else
                            idx_q <= idx_q + 1'b1;
                    end
                    PARITY: begin
                        par_q   <= dat_s2_q;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        // A bad stop bit masks a parity error.
                        if (!dat_s2_q)
                            err_frame_q <= 1'b1;
                        else if (^{shift_q, par_q})
                            push_q <= 1'b1;
                        else
                            err_parity_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q == IDLE) begin
                wd_q <= '0;
            end else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_q       <= IDLE;
                wd_q          <= '0;
                err_timeout_q <= 1'b1;
            end else begin
                wd_q <= wd_q + 1'b1;
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  full, pop, push_ok;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = valid & ready;
    // When full, a simultaneous pop frees the slot this push needs.
    assign push_ok = push_q & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign valid        = (count_q != '0);
    assign data_out     = valid ? mem_q[rd_ptr_q] : '0;
    assign count        = count_q;
    assign err_parity   = err_parity_q;
    assign err_frame    = err_frame_q;
    assign err_timeout  = err_timeout_q;
    assign err_overflow = push_q & full & ~pop;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset, ps2_clk, ps2_data, ready;
    logic [DW-1:0] data_out;
    logic          valid;
    logic [2:0]    count;
    logic          err_parity, err_frame, err_timeout, err_overflow;

    ps2_rx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FILTER_LEN(4),
                  .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .data_out(data_out), .valid(valid), .ready(ready), .count(count),
        .err_parity(err_parity), .err_frame(err_frame),
        .err_timeout(err_timeout), .err_overflow(err_overflow));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: collects delivered bytes and error pulses.
    logic [DW-1:0] rxq[$];
    int n_par = 0, n_frm = 0, n_to = 0, n_ovf = 0, valid_cyc = 0, viol = 0;
    logic p_par = 0, p_frm = 0, p_to = 0, p_ovf = 0;

    always @(negedge clk) begin
        if (reset) begin
            p_par = 0; p_frm = 0; p_to = 0; p_ovf = 0;
        end else begin
            if (valid && ready) begin
                rxq.push_back(data_out);
                valid_cyc++;
            end
            n_par += int'(err_parity);
            n_frm += int'(err_frame);
            n_to  += int'(err_timeout);
            n_ovf += int'(err_overflow);
            if ((err_parity && p_par) || (err_frame && p_frm) ||
                (err_timeout && p_to) || (err_overflow && p_ovf))
                viol++;
            if (int'(err_parity) + int'(err_frame) + int'(err_timeout) +
                int'(err_overflow) > 1)
                viol++;
            p_par = err_parity; p_frm = err_frame;
            p_to = err_timeout; p_ovf = err_overflow;
        end
    end

    logic rnd_ready = 0;
    initial forever begin
        @(posedge clk); #1;
        if (rnd_ready) ready = 1'($urandom_range(0, 1));
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // One PS/2 bit: data set up while the clock is high, then a low phase.
    task automatic send_bit(input logic b, input logic glitch);
        ps2_data = b;
        for (int k = 0; k < 10; k++) begin
            if (glitch && k == 5) ps2_clk = 1'b0;
            else ps2_clk = 1'b1;
            cyc();
        end
        ps2_clk = 1'b0;
        repeat (20) cyc();
        ps2_clk = 1'b1;
        repeat (10) cyc();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop_v, input int nbits,
                              input int glitch_at);
        logic [10:0] b;
        b[0] = 1'b0;
        b[8:1] = d;
        b[9] = ~(^d) ^ par_flip;
        b[10] = stop_v;
        for (int i = 0; i < nbits; i++) send_bit(b[i], i == glitch_at);
        ps2_data = 1'b1;
        repeat (20) cyc();
    endtask

    task automatic drain();
        ready = 1'b1;
        repeat (10) cyc();
        ready = 1'b0;
        cyc();
    endtask

    int e0, e1, v0;
    logic [DW-1:0] expq[$];

    initial begin
        ps2_clk = 1; ps2_data = 1; ready = 0; reset = 1;
        repeat (5) cyc();
        chk("rst_valid", valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_count", count, 0);
        chk("rst_errs", {err_parity, err_frame, err_timeout, err_overflow}, 0);
        reset = 0;
        repeat (5) cyc();

        // single frame, ready low
        send_frame(8'h1C, 0, 1, 11, -1);
        chk("f1c_valid", valid, 1);
        chk("f1c_data", data_out, 8'h1C);
        chk("f1c_count", count, 1);
        chk("f1c_noerr", n_par + n_frm + n_to + n_ovf, 0);
        drain();
        chk("f1c_drained", count, 0);
        chk("f1c_rx", (rxq.size() == 1) ? int'(rxq[0]) : -1, 8'h1C);
        rxq.delete();

        // two frames, ready held high
        ready = 1; v0 = valid_cyc;
        send_frame(8'hF0, 0, 1, 11, -1);
        send_frame(8'h1C, 0, 1, 11, -1);
        chk("hs_cycles", valid_cyc - v0, 2);
        chk("hs_rx0", (rxq.size() == 2) ? int'(rxq[0]) : -1, 8'hF0);
        chk("hs_rx1", (rxq.size() == 2) ? int'(rxq[1]) : -1, 8'h1C);
        chk("hs_count", count, 0);
        ready = 0; rxq.delete();

        // parity error
        e0 = n_par; e1 = n_frm;
        send_frame(8'h1C, 1, 1, 11, -1);
        chk("par_pulse", n_par - e0, 1);
        chk("par_count", count, 0);
        // stop error, good parity, then stop error with bad parity too
        send_frame(8'h1C, 0, 0, 11, -1);
        send_frame(8'h1C, 1, 0, 11, -1);
        chk("frm_pulse", n_frm - e1, 2);
        chk("frm_nopar", n_par - e0, 1);
        chk("frm_count", count, 0);

        // timeout after start + 3 data bits
        e0 = n_to;
        send_frame(8'hF0, 0, 1, 4, -1);
        repeat (300) cyc();
        chk("to_pulse", n_to - e0, 1);
        send_frame(8'hF0, 0, 1, 11, -1);
        chk("to_after_data", data_out, 8'hF0);
        chk("to_after_count", count, 1);
        drain(); rxq.delete();

        // overflow
        e0 = n_ovf;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 0, 1, 11, -1);
        chk("ovf_full", count, 4);
        chk("ovf_none_yet", n_ovf - e0, 0);
        send_frame(8'h05, 0, 1, 11, -1);
        chk("ovf_pulse", n_ovf - e0, 1);
        chk("ovf_count", count, 4);
        drain();
        chk("ovf_nrx", rxq.size(), 4);
        for (int i = 0; i < 4 && i < rxq.size(); i++)
            chk("ovf_order", rxq[i], i + 1);
        rxq.delete();

        // 1-cycle low glitch inside a frame must not add a bit
        send_frame(8'h5A, 0, 1, 11, 3);
        chk("glitch_data", data_out, 8'h5A);
        chk("glitch_count", count, 1);
        drain(); rxq.delete();

        // reset mid-frame
        send_frame(8'h33, 0, 1, 11, -1);
        send_frame(8'hC3, 0, 1, 5, -1);
        reset = 1;
        cyc();
        chk("rmid_valid", valid, 0);
        chk("rmid_count", count, 0);
        chk("rmid_data", data_out, 0);
        reset = 0;
        repeat (5) cyc();
        send_frame(8'hA5, 0, 1, 11, -1);
        chk("rmid_next", data_out, 8'hA5);
        chk("rmid_next_count", count, 1);
        drain(); rxq.delete();

        // randomized frames against a queue model
        e0 = n_par; e1 = n_frm; v0 = n_ovf;
        begin
            int ep = 0, ef = 0;
            rnd_ready = 1;
            for (int i = 0; i < 16; i++) begin
                int kind;
                logic [7:0] d;
                kind = $urandom_range(0, 9);
                d = 8'($urandom_range(0, 255));
                if (kind < 7) begin
                    expq.push_back(d);
                    send_frame(d, 0, 1, 11, -1);
                end else if (kind < 9) begin
                    ep++;
                    send_frame(d, 1, 1, 11, -1);
                end else begin
                    ef++;
                    send_frame(d, $urandom_range(0, 1), 0, 11, -1);
                end
            end
            rnd_ready = 0;
            cyc();
            drain();
            chk("rnd_par", n_par - e0, ep);
            chk("rnd_frm", n_frm - e1, ef);
        end
        chk("rnd_nrx", rxq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < rxq.size(); i++)
            chk("rnd_byte", rxq[i], expq[i]);
        chk("rnd_noovf", n_ovf - v0, 0);

        chk("to_total", n_to, 1);
        chk("pulse_shape", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 device-to-host receiver clocked by the system clock.
- Samples the raw ps2_clk and ps2_data lines, filters and edge-detects ps2_clk, and deframes 11-bit frames: start, DATA_WIDTH data bits LSB-first, odd parity, stop.
- Good frames go into an internal FIFO with a valid/ready output.
- Parity, framing, timeout and overflow errors are flagged.
- Sits between the PS/2 pins and the keyboard scan-code decoder.

Parameters:
DATA_WIDTH, 8, payload bits per frame
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2
FILTER_LEN, 4, consecutive equal synchronised samples needed to change filtered ps2_clk level; >= 1
TIMEOUT_CYCLES, 50000, clk cycles allowed between falling edges inside a frame before abort; >= 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock line, asynchronous
ps2_data  in  1  raw PS/2 data line, asynchronous
data_out  out  DATA_WIDTH  FIFO head byte, meaningful while valid=1
valid  out  1  FIFO non-empty
ready  in  1  consumer accepts head when valid&ready at a rising clk edge
count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
err_parity  out  1  one-cycle pulse: frame dropped, parity not odd
err_frame  out  1  one-cycle pulse: frame dropped, stop bit = 0
err_timeout  out  1  one-cycle pulse: frame aborted by watchdog
err_overflow  out  1  one-cycle pulse: good frame dropped, FIFO full

Behaviour:
- Reset:
  - data_out=0, valid=0, count=0, all err_* = 0.
  - FSM in IDLE, FIFO empty.
  - Synchroniser and filter registers = 1 (bus idle high).
  - Reset mid-frame discards the partial frame silently.
- Input conditioning:
  - Both lines pass through a 2-FF synchroniser.
  - Filtered clock changes level only after FILTER_LEN consecutive equal synchronised samples.
  - Falling edge = filtered clock 1->0, registered as a single-cycle strobe.
  - ps2_data (synchronised) is sampled on that strobe cycle.
- FSM (advances only on falling-edge strobes, except timeout):
  - IDLE: sampled 0 -> DATA, bit index = 0. Sampled 1 -> stay IDLE, no error.
  - DATA: shift the sample into bit[index], LSB first. After bit DATA_WIDTH-1 -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: always -> IDLE, with exactly one of:
    - sample=1 and data^parity has odd ones: push, or assert err_overflow if the push is refused;
    - sample=1 and parity bad: err_parity;
    - sample=0: err_frame. A stop=0 frame with bad parity reports err_frame only.
- Watchdog:
  - Counter clears on every strobe and while in IDLE.
  - In any other state, reaching TIMEOUT_CYCLES without a strobe forces IDLE and pulses err_timeout for one cycle.
- FIFO (first-word fall-through):
  - A push in cycle N makes data visible with valid=1 in cycle N+1 if the FIFO was empty.
  - Pop on valid&ready. Pop while empty is ignored.
  - Simultaneous push and pop when full: both happen, count unchanged, no overflow.
  - Simultaneous push and pop when empty: only the push happens.
  - Pointers wrap modulo FIFO_DEPTH. count = FIFO_DEPTH means full.
- Latency: err_*/push occur in the cycle following the stop-bit strobe.
- All err_* pulses are mutually exclusive and never longer than one cycle.

Test Plan:
- Frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1), ready=0:
  - valid=1, data_out=0x1C, count=1, no err pulse.
- Frames 0xF0 (parity 1) then 0x1C, ready held 1:
  - two single-cycle valid handshakes delivering 0xF0 then 0x1C; count returns to 0.
- Frame 0x1C with parity bit 1:
  - err_parity pulses once, count stays 0.
- Same frame, parity ok, stop 0:
  - err_frame pulses once, count stays 0.
- Start bit plus 3 data bits, then ps2_clk held high (TIMEOUT_CYCLES=100):
  - err_timeout pulses exactly once, FSM in IDLE.
  - A following valid 0xF0 frame is received correctly.
- FIFO_DEPTH=4, ready=0, send 5 good frames 0x01..0x05:
  - count=4, err_overflow pulses on frame 5.
  - Draining yields 0x01,0x02,0x03,0x04.
- Glitch checks:
  - 1-cycle low glitch on ps2_clk with FILTER_LEN=4: no strobe, no state change.
  - reset asserted mid-frame: all outputs return to reset values next cycle.
